// File: rtl/keystream_xor_pkg.sv
// Shared types for the keystream XOR stage.
// Provides the word/keep types, block size, FSM state encoding, the
// ciphertext beat payload and a byte-masking helper.
package keystream_xor_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned KEEP_W         = 4;
  localparam int unsigned KS_BLOCK_WORDS = 16;
  // Outstanding/drop counters hold 0..KS_BLOCK_WORDS inclusive.
  localparam int unsigned OUT_W          = $clog2(KS_BLOCK_WORDS) + 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEEP_W-1:0] keep_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    word_t data;
    keep_t keep;
    logic  last;
  } ct_beat_t;

  // Zero every byte whose keep bit is clear.
  function automatic word_t mask_bytes(word_t w, keep_t k);
    word_t m;
    m = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      m[i*8 +: 8] = k[i] ? w[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/keystream_xor_ks_fifo.sv
// Synchronous keystream FIFO with first-word fall-through head and flush.
// Ports: clk_i, rst_ni (async active-low), wr_en_i/wr_data_i write side,
// rd_en_i/rd_data_o read side, flush_i empties the FIFO (including a
// same-cycle write), count_o/full_o/empty_o occupancy.
module keystream_xor_ks_fifo
  import keystream_xor_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  word_t         wr_data_i,
  input  logic          rd_en_i,
  input  logic          flush_i,
  output word_t         rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full FIFO is accepted only if a read frees a slot.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Pointer/count next state; flush snaps the read pointer onto the
  // post-write write pointer so a same-cycle write is discarded too.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (flush_i) begin
      rd_ptr_d = wr_ptr_d;
      count_d  = '0;
    end else begin
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/keystream_xor.sv
// Keystream XOR stage: buffers serialiser keystream words, requests new
// 16-word blocks, XORs a valid/ready plaintext stream into ciphertext and
// discards leftover keystream at end of message.
// Ports: clk_i, rst_ni (async active-low); ks_word_i/ks_valid_i keystream
// in; block_req_o block request pulse; pt_* plaintext in (valid/ready);
// ct_* ciphertext out (valid/ready); ks_overflow_o sticky overflow flag.
module keystream_xor
  import keystream_xor_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  word_t ks_word_i,
  input  logic  ks_valid_i,
  output logic  block_req_o,
  input  word_t pt_data_i,
  input  keep_t pt_keep_i,
  input  logic  pt_last_i,
  input  logic  pt_valid_i,
  output logic  pt_ready_o,
  output word_t ct_data_o,
  output keep_t ct_keep_o,
  output logic  ct_last_o,
  output logic  ct_valid_o,
  input  logic  ct_ready_i,
  output logic  ks_overflow_o
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             block_req_q, block_req_d;
  logic             overflow_q, overflow_d;
  ct_beat_t         ct_q, ct_d;
  logic             ct_valid_q, ct_valid_d;

  word_t            ks_head;
  logic [CW-1:0]    ks_count;
  logic [CW-1:0]    free_slots;
  logic             ks_full, ks_empty;
  logic             hs, fifo_wr, flush;

  // Accept plaintext only with keystream available and room in the output register.
  assign pt_ready_o = (state_q == ST_RUN) && !ks_empty && (!ct_valid_q || ct_ready_i);
  assign hs         = pt_valid_i && pt_ready_o;
  assign fifo_wr    = ks_valid_i && (state_q == ST_RUN);
  assign flush      = hs && pt_last_i;
  assign free_slots = CW'(DEPTH) - ks_count;

  keystream_xor_ks_fifo #(.DEPTH(DEPTH)) u_ks_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (fifo_wr),
    .wr_data_i (ks_word_i),
    .rd_en_i   (hs),
    .flush_i   (flush),
    .rd_data_o (ks_head),
    .count_o   (ks_count),
    .full_o    (ks_full),
    .empty_o   (ks_empty)
  );

  // Next-state logic for FSM, counters, request pulse and output register.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    ct_d          = ct_q;
    ct_valid_d    = ct_valid_q;
    overflow_d    = overflow_q || (fifo_wr && ks_full && !hs);

    // Gated on the current pulse because outstanding only reflects it one cycle later.
    block_req_d = (state_q == ST_RUN) && (outstanding_q == '0) &&
                  (free_slots >= CW'(KS_BLOCK_WORDS)) && !block_req_q;

    if (block_req_q) outstanding_d = outstanding_q + OUT_W'(KS_BLOCK_WORDS);
    if (ks_valid_i && (outstanding_d != '0)) outstanding_d = outstanding_d - OUT_W'(1);

    // drop_cnt tracks outstanding so a request issued alongside pt_last is also dropped.
    if (state_q == ST_RUN) begin
      if (flush) begin
        state_d    = ST_DRAIN;
        drop_cnt_d = outstanding_d;
      end
    end else begin
      if (drop_cnt_q == '0) begin
        state_d = ST_RUN;
      end else if (ks_valid_i) begin
        drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end
    end

    if (hs) begin
      ct_d.data  = mask_bytes(pt_data_i ^ ks_head, pt_keep_i);
      ct_d.keep  = pt_keep_i;
      ct_d.last  = pt_last_i;
      ct_valid_d = 1'b1;
    end else if (ct_ready_i) begin
      ct_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      block_req_q   <= 1'b0;
      overflow_q    <= 1'b0;
      ct_q          <= '0;
      ct_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      block_req_q   <= block_req_d;
      overflow_q    <= overflow_d;
      ct_q          <= ct_d;
      ct_valid_q    <= ct_valid_d;
    end
  end

  assign block_req_o   = block_req_q;
  assign ks_overflow_o = overflow_q;
  assign ct_data_o     = ct_q.data;
  assign ct_keep_o     = ct_q.keep;
  assign ct_last_o     = ct_q.last;
  assign ct_valid_o    = ct_valid_q;

endmodule

// File: tb/tb_keystream_xor.sv
// Scoreboard bench for keystream_xor: stimulus pushes hand-computed
// ciphertext beats, a negedge monitor pops and compares them.
module tb_keystream_xor;
  import keystream_xor_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t ks_word_i;
  logic  ks_valid_i;
  logic  block_req_o;
  word_t pt_data_i;
  keep_t pt_keep_i;
  logic  pt_last_i;
  logic  pt_valid_i;
  logic  pt_ready_o;
  word_t ct_data_o;
  keep_t ct_keep_o;
  logic  ct_last_o;
  logic  ct_valid_o;
  logic  ct_ready_i;
  logic  ks_overflow_o;

  int checks = 0;
  int errors = 0;
  int req_pulses = 0;
  int cyc = 0;
  int t0;
  ct_beat_t exp_q[$];
  ct_beat_t mon_e;

  always #5 clk = ~clk;

  keystream_xor #(.DEPTH(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ks_word_i     (ks_word_i),
    .ks_valid_i    (ks_valid_i),
    .block_req_o   (block_req_o),
    .pt_data_i     (pt_data_i),
    .pt_keep_i     (pt_keep_i),
    .pt_last_i     (pt_last_i),
    .pt_valid_i    (pt_valid_i),
    .pt_ready_o    (pt_ready_o),
    .ct_data_o     (ct_data_o),
    .ct_keep_o     (ct_keep_o),
    .ct_last_o     (ct_last_o),
    .ct_valid_o    (ct_valid_o),
    .ct_ready_i    (ct_ready_i),
    .ks_overflow_o (ks_overflow_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && block_req_o) req_pulses++;
  end

  // Scoreboard monitor: every accepted ct beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && ct_valid_o && ct_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ct_unexpected: got %h with nothing expected", ct_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("ct_data", ct_data_o, mon_e.data);
        check("ct_keep", 32'(ct_keep_o), 32'(mon_e.keep));
        check("ct_last", 32'(ct_last_o), 32'(mon_e.last));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic feed(input word_t w);
    ks_word_i  = w;
    ks_valid_i = 1'b1;
    @(posedge clk); #1;
    ks_valid_i = 1'b0;
  endtask

  task automatic send(input word_t d, input keep_t k, input logic l, input word_t exp);
    int  waits = 0;
    bit  done = 1'b0;
    pt_data_i  = d;
    pt_keep_i  = k;
    pt_last_i  = l;
    pt_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (pt_ready_o) begin
        exp_q.push_back('{data: exp, keep: k, last: l});
        done = 1'b1;
      end else begin
        waits++;
        if (waits >= 40) begin
          checks++;
          errors++;
          $display("FAIL pt_handshake_timeout: got no pt_ready expected handshake for %h", d);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    pt_valid_i = 1'b0;
    if (waits < 40) check("latency_ct_valid", 32'(ct_valid_o), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    ks_word_i  = '0;
    ks_valid_i = 1'b0;
    pt_data_i  = '0;
    pt_keep_i  = 4'hF;
    pt_last_i  = 1'b0;
    pt_valid_i = 1'b0;
    ct_ready_i = 1'b1;

    // Reset state and first request pulse
    repeat (3) @(posedge clk);
    #1;
    check("rst_block_req", 32'(block_req_o), 32'd0);
    check("rst_ct_valid", 32'(ct_valid_o), 32'd0);
    check("rst_pt_ready", 32'(pt_ready_o), 32'd0);
    check("rst_overflow", 32'(ks_overflow_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); check("req_cycle1", 32'(block_req_o), 32'd0);
    @(negedge clk); check("req_cycle2", 32'(block_req_o), 32'd1);
    @(negedge clk); check("req_cycle3", 32'(block_req_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("idle_pt_ready", 32'(pt_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    check("req_idle_single", 32'(req_pulses), 32'd1);

    // Block 0..F, then 16 full-throughput words of all-ones plaintext
    for (int i = 0; i < 16; i++) feed(word_t'(i));
    repeat (2) @(posedge clk);
    #1;
    check("req_after_block", 32'(req_pulses), 32'd2);
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(32'hFFFF_FFFF, 4'hF, 1'b0, ~word_t'(i));
    check("throughput_cycles", 32'(cyc - t0), 32'd16);
    wait_idle();

    // 3-word message, last partial; 13 leftover words flushed
    for (int i = 0; i < 16; i++) feed((i == 2) ? 32'hAABB_CCDD : (32'h5A5A_0000 | word_t'(i)));
    send(32'h1122_3344, 4'hF, 1'b0, 32'h4B78_3344);
    send(32'h1122_3344, 4'hF, 1'b0, 32'h4B78_3345);
    send(32'h1122_3344, 4'h3, 1'b1, 32'h0000_FF99);
    check("req_block3", 32'(req_pulses), 32'd3);

    // In-flight block is dropped while DRAIN; no pt_ready, no request
    for (int i = 0; i < 16; i++) begin
      ks_word_i  = 32'hDEAD_0000 | word_t'(i);
      ks_valid_i = 1'b1;
      pt_data_i  = '0;
      pt_keep_i  = 4'hF;
      pt_last_i  = 1'b0;
      pt_valid_i = 1'b1;
      @(negedge clk); check("drain_pt_ready", 32'(pt_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    ks_valid_i = 1'b0;
    pt_valid_i = 1'b0;
    check("drain_no_req", 32'(req_pulses), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check("req_after_drain", 32'(req_pulses), 32'd4);

    // Next message starts at word 0 of the fresh block
    for (int i = 0; i < 16; i++) feed(32'h0C0C_0C00 | word_t'(i));
    send(32'h0000_0000, 4'hF, 1'b0, 32'h0C0C_0C00);
    for (int i = 0; i < 16; i++) feed(32'h5050_0000 | word_t'(i));
    repeat (2) @(posedge clk);
    #1;
    check("req_fifo_nearly_full", 32'(req_pulses), 32'd5);

    // pt_last with nothing outstanding: DRAIN lasts one cycle
    send(32'hFFFF_0000, 4'hC, 1'b1, 32'hF3F3_0000);
    @(negedge clk); check("drain0_pt_ready", 32'(pt_ready_o), 32'd0);
    @(negedge clk); check("drain1_block_req", 32'(block_req_o), 32'd0);
    @(negedge clk); check("drain2_block_req", 32'(block_req_o), 32'd1);
    @(posedge clk); #1;
    wait_idle();

    // Output backpressure mid-stream
    for (int i = 0; i < 16; i++) feed(32'h0000_0030 + word_t'(i));
    for (int i = 0; i < 3; i++) send(32'h1234_5678, 4'hF, 1'b0, 32'h1234_5648 + word_t'(i));
    ct_ready_i = 1'b0;
    pt_data_i  = 32'h1234_5678;
    pt_keep_i  = 4'hF;
    pt_last_i  = 1'b0;
    pt_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ct_valid", 32'(ct_valid_o), 32'd1);
      check("stall_ct_data", ct_data_o, 32'h1234_564A);
      check("stall_pt_ready", 32'(pt_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    ct_ready_i = 1'b1;
    for (int i = 3; i < 6; i++) send(32'h1234_5678, 4'hF, 1'b0, 32'h1234_5648 + word_t'(i));
    wait_idle();

    // Overflow: fill 32 words, then 17 extra with no reads
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) feed(32'h0000_0600 + word_t'(i));
    check("overflow_full_no_drop", 32'(ks_overflow_o), 32'd0);
    feed(32'h0000_0700);
    check("overflow_first_drop", 32'(ks_overflow_o), 32'd1);
    for (int i = 1; i < 17; i++) feed(32'h0000_0700 + word_t'(i));
    repeat (3) @(posedge clk);
    #1;
    check("overflow_sticky", 32'(ks_overflow_o), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("overflow_cleared_by_rst", 32'(ks_overflow_o), 32'd0);
    check("rst_async_block_req", 32'(block_req_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
